// File: rtl/entity_pkg.sv
// entity_pkg: packed entity word layout, velocity format and screen wrap helper
package entity_pkg;
  localparam int ENTITY_SIZE = 34;
  localparam int VALID_BIT = 33;
  localparam int KIND_LSB = 30;
  localparam int LIFE_LSB = 26;
  localparam int Y_LSB = 16;
  localparam int X_LSB = 6;
  localparam int VEL_LSB = 0;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  typedef struct packed {
    logic sign_y;
    logic [1:0] mag_y;
    logic sign_x;
    logic [1:0] mag_x;
  } vel_t;
  typedef struct packed {
    logic valid;
    logic [2:0] kind;
    logic [3:0] life;
    logic [9:0] y;
    logic [9:0] x;
    vel_t vel;
  } entity_t;
  function automatic logic [9:0] wrap_step(input logic [9:0] p, input logic dec, input logic [1:0] mag, input logic [10:0] lim);
    logic [10:0] w, m;
    w = {1'b0, p};
    m = {9'd0, mag};
    return 10'(dec ? (m > w ? w + lim - m : w - m) : (w + m >= lim ? w + m - lim : w + m));
  endfunction
endpackage

// File: rtl/entity_step.sv
// entity_step: combinational next state of one slot on a movement tick
module entity_step import entity_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                   tick,
  input  logic [ENTITY_SIZE-1:0] cur,
  output logic [ENTITY_SIZE-1:0] nxt
);
  entity_t e, m;
  always_comb begin
    e = entity_t'(cur);
    m = e;
    m.x = wrap_step(e.x, e.vel.sign_x, e.vel.mag_x, 11'(SCREEN_W));
    m.y = wrap_step(e.y, e.vel.sign_y, e.vel.mag_y, 11'(SCREEN_H));
    m.life = e.life == 4'd0 ? 4'd0 : e.life - 4'd1;
    nxt = !e.valid || !tick ? cur : e.life == 4'd1 ? '0 : m;
  end
endmodule

// File: rtl/entity_pool.sv
// entity_pool: slot table of moving entities with spawn, delete, wrap and expiry
module entity_pool import entity_pkg::*; #(
  parameter int N_SLOTS = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1
) (
  input  logic                           move_clk,
  input  logic                           reset_n,
  input  logic                           tick,
  input  logic                           spawn_valid,
  output logic                           spawn_ready,
  input  logic [2:0]                     spawn_kind,
  input  logic [3:0]                     spawn_life,
  input  logic [9:0]                     spawn_x,
  input  logic [9:0]                     spawn_y,
  input  logic [5:0]                     spawn_vel,
  output logic [ADDR_W-1:0]              spawn_addr,
  input  logic                           del_valid,
  input  logic [ADDR_W-1:0]              del_addr,
  output logic [N_SLOTS*ENTITY_SIZE-1:0] entities,
  output logic [ADDR_W:0]                count,
  output logic                           empty,
  output logic                           full
);
  entity_t slot_q [N_SLOTS];
  entity_t slot_d [N_SLOTS];
  logic [ENTITY_SIZE-1:0] stepped [N_SLOTS];
  logic [ADDR_W-1:0] free_idx;
  logic [ADDR_W:0] cnt_d;
  logic accept;
  entity_t spawn_e;
  genvar i;
  for (i = 0; i < N_SLOTS; i++) begin : g_slot
    entity_step #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_step (
      .tick(tick),
      .cur(slot_q[i]),
      .nxt(stepped[i])
    );
    assign entities[i*ENTITY_SIZE +: ENTITY_SIZE] = slot_q[i];
  end
  always_comb begin
    spawn_ready = 1'b0;
    free_idx = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--)
      if (!slot_q[k].valid) begin
        spawn_ready = 1'b1;
        free_idx = ADDR_W'(k);
      end
    accept = spawn_valid && spawn_ready;
    spawn_e = '{valid: 1'b1, kind: spawn_kind, life: spawn_life, y: spawn_y, x: spawn_x, vel: vel_t'(spawn_vel)};
    cnt_d = '0;
    // a spawn only ever targets a free slot, so a delete there is already a no-op
    for (int k = 0; k < N_SLOTS; k++) begin
      slot_d[k] = accept && free_idx == ADDR_W'(k) ? spawn_e
                : del_valid && del_addr == ADDR_W'(k) ? '0
                : entity_t'(stepped[k]);
      cnt_d = cnt_d + (ADDR_W+1)'(slot_d[k].valid);
    end
  end
  always_ff @(posedge move_clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N_SLOTS; k++) slot_q[k] <= '0;
      spawn_addr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
    end else begin
      for (int k = 0; k < N_SLOTS; k++) slot_q[k] <= slot_d[k];
      if (accept) spawn_addr <= free_idx;
      count <= cnt_d;
      empty <= cnt_d == '0;
      full <= cnt_d == (ADDR_W+1)'(N_SLOTS);
    end
  end
endmodule

// File: tb/tb_entity_pool.sv
// tb_entity_pool: scoreboard bench for entity_pool with three slots
module tb_entity_pool;
  logic move_clk = 0, reset_n = 0, tick = 0, spawn_valid = 0, del_valid = 0;
  logic spawn_ready, empty, full;
  logic [2:0] spawn_kind = 0;
  logic [3:0] spawn_life = 0;
  logic [9:0] spawn_x = 0, spawn_y = 0;
  logic [5:0] spawn_vel = 0;
  logic [1:0] spawn_addr, del_addr = 0;
  logic [101:0] entities;
  logic [2:0] count;
  int total = 0, bad = 0;
  logic [101:0] exp_q[$];
  logic [101:0] exp_b;

  entity_pool dut (
    .move_clk(move_clk), .reset_n(reset_n), .tick(tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_kind(spawn_kind), .spawn_life(spawn_life),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_vel(spawn_vel),
    .spawn_addr(spawn_addr), .del_valid(del_valid), .del_addr(del_addr),
    .entities(entities), .count(count), .empty(empty), .full(full)
  );

  always #5 move_clk = ~move_clk;

  function automatic logic [33:0] ent(input logic [2:0] k, input logic [3:0] l, input logic [9:0] y, input logic [9:0] x, input logic [5:0] v);
    return {1'b1, k, l, y, x, v};
  endfunction

  task automatic cycle();
    @(posedge move_clk);
    #1;
  endtask

  task automatic idle();
    spawn_valid = 0;
    del_valid = 0;
    tick = 0;
  endtask

  task automatic spawn_set(input logic [33:0] w);
    spawn_valid = 1;
    spawn_kind = w[32:30];
    spawn_life = w[29:26];
    spawn_y = w[25:16];
    spawn_x = w[15:6];
    spawn_vel = w[5:0];
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    cycle();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    exp_q.push_back('0);
    cycle();
    reset_n = 1;
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL reset_entities got=%h exp=%h", entities, exp_b); end
    total++; if ({count, empty, full, spawn_ready, spawn_addr} !== {3'd0, 1'b1, 1'b0, 1'b1, 2'd0})
      begin bad++; $display("FAIL reset_flags got cnt=%0d e=%b f=%b rdy=%b addr=%0d exp 0 1 0 1 0", count, empty, full, spawn_ready, spawn_addr); end
  endtask

  task automatic test_fill();
    logic [33:0] e [3];
    logic [101:0] b;
    e[0] = ent(3'd1, 4'd0, 10'd100, 10'd50, 6'o01);
    e[1] = ent(3'd2, 4'd5, 10'd20, 10'd300, 6'o22);
    e[2] = ent(3'd3, 4'd9, 10'd239, 10'd0, 6'o45);
    b = '0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      spawn_set(e[k]);
      b[k*34 +: 34] = e[k];
      exp_q.push_back(b);
      cycle();
      exp_b = exp_q.pop_front();
      total++; if (entities !== exp_b) begin bad++; $display("FAIL fill%0d_entities got=%h exp=%h", k, entities, exp_b); end
      total++; if (spawn_addr !== 2'(k)) begin bad++; $display("FAIL fill%0d_addr got=%0d exp=%0d", k, spawn_addr, k); end
      total++; if (count !== 3'(k + 1)) begin bad++; $display("FAIL fill%0d_count got=%0d exp=%0d", k, count, k + 1); end
    end
    total++; if ({full, empty, spawn_ready} !== 3'b100) begin bad++; $display("FAIL fill_full got f=%b e=%b rdy=%b exp 1 0 0", full, empty, spawn_ready); end
    spawn_set(ent(3'd4, 4'd1, 10'd1, 10'd1, 6'o00));
    exp_q.push_back(b);
    cycle();
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL drop_entities got=%h exp=%h", entities, exp_b); end
    total++; if ({spawn_addr, count} !== {2'd2, 3'd3}) begin bad++; $display("FAIL drop_addr_count got addr=%0d cnt=%0d exp 2 3", spawn_addr, count); end
  endtask

  task automatic test_wrap();
    do_reset();
    spawn_set(ent(3'd1, 4'd0, 10'd5, 10'd318, 6'b000011));
    cycle();
    spawn_set(ent(3'd2, 4'd0, 10'd1, 10'd20, 6'b110000));
    cycle();
    idle();
    tick = 1;
    exp_q.push_back({34'd0, ent(3'd2, 4'd0, 10'd239, 10'd20, 6'b110000), ent(3'd1, 4'd0, 10'd5, 10'd1, 6'b000011)});
    cycle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL wrap1 got=%h exp=%h", entities, exp_b); end
    exp_q.push_back({34'd0, ent(3'd2, 4'd0, 10'd237, 10'd20, 6'b110000), ent(3'd1, 4'd0, 10'd5, 10'd4, 6'b000011)});
    cycle();
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL wrap2 got=%h exp=%h", entities, exp_b); end
  endtask

  task automatic test_life();
    logic [33:0] im;
    im = ent(3'd2, 4'd0, 10'd30, 10'd7, 6'o00);
    do_reset();
    spawn_set(ent(3'd1, 4'd2, 10'd10, 10'd10, 6'o00));
    cycle();
    spawn_set(im);
    cycle();
    idle();
    tick = 1;
    exp_q.push_back({34'd0, im, ent(3'd1, 4'd1, 10'd10, 10'd10, 6'o00)});
    cycle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL life_tick1 got=%h exp=%h", entities, exp_b); end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL life_count1 got=%0d exp=2", count); end
    exp_q.push_back({34'd0, im, 34'd0});
    cycle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL life_expire got=%h exp=%h", entities, exp_b); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL life_count2 got=%0d exp=1", count); end
    exp_q.push_back({34'd0, im, 34'd0});
    repeat (18) cycle();
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL life_immortal got=%h exp=%h", entities, exp_b); end
  endtask

  task automatic test_del_spawn();
    logic [33:0] a, b, c, d;
    a = ent(3'd1, 4'd0, 10'd1, 10'd2, 6'o00);
    b = ent(3'd2, 4'd0, 10'd3, 10'd4, 6'o00);
    c = ent(3'd3, 4'd0, 10'd5, 10'd6, 6'o00);
    d = ent(3'd7, 4'd3, 10'd200, 10'd100, 6'o77);
    do_reset();
    spawn_set(a); cycle();
    spawn_set(b); cycle();
    spawn_set(c); cycle();
    idle();
    del_valid = 1;
    del_addr = 2'd3;
    exp_q.push_back({c, b, a});
    cycle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL del_oob got=%h exp=%h", entities, exp_b); end
    del_addr = 2'd1;
    spawn_set(d);
    exp_q.push_back({c, 34'd0, a});
    cycle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL del_full_spawn got=%h exp=%h", entities, exp_b); end
    total++; if ({spawn_addr, count, full, spawn_ready} !== {2'd2, 3'd2, 1'b0, 1'b1})
      begin bad++; $display("FAIL del_flags got addr=%0d cnt=%0d f=%b rdy=%b exp 2 2 0 1", spawn_addr, count, full, spawn_ready); end
    del_valid = 0;
    exp_q.push_back({c, d, a});
    cycle();
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL respawn got=%h exp=%h", entities, exp_b); end
    total++; if ({spawn_addr, full} !== {2'd1, 1'b1}) begin bad++; $display("FAIL respawn_addr got addr=%0d f=%b exp 1 1", spawn_addr, full); end
  endtask

  task automatic test_spawn_tick();
    do_reset();
    spawn_set(ent(3'd5, 4'd0, 10'd50, 10'd10, 6'b000001));
    tick = 1;
    exp_q.push_back({68'd0, ent(3'd5, 4'd0, 10'd50, 10'd10, 6'b000001)});
    cycle();
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL spawn_tick got=%h exp=%h", entities, exp_b); end
    tick = 1;
    exp_q.push_back({68'd0, ent(3'd5, 4'd0, 10'd50, 10'd11, 6'b000001)});
    cycle();
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL spawn_tick_next got=%h exp=%h", entities, exp_b); end
  endtask

  task automatic test_reset_mid();
    spawn_set(ent(3'd6, 4'd4, 10'd9, 10'd9, 6'o11));
    cycle();
    tick = 1;
    del_valid = 1;
    del_addr = 2'd0;
    spawn_set(ent(3'd2, 4'd2, 10'd8, 10'd8, 6'o01));
    reset_n = 0;
    exp_q.push_back('0);
    cycle();
    reset_n = 1;
    idle();
    exp_b = exp_q.pop_front();
    total++; if (entities !== exp_b) begin bad++; $display("FAIL reset_mid_entities got=%h exp=%h", entities, exp_b); end
    total++; if ({count, empty, full, spawn_ready, spawn_addr} !== {3'd0, 1'b1, 1'b0, 1'b1, 2'd0})
      begin bad++; $display("FAIL reset_mid_flags got cnt=%0d e=%b f=%b rdy=%b addr=%0d exp 0 1 0 1 0", count, empty, full, spawn_ready, spawn_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_life();
    test_del_spawn();
    test_spawn_tick();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/entity_pool.md
# entity_pool

Parametrised slot table that holds N_SLOTS game entities (shots or asteroids) in the 34-bit packed entity format and advances them every movement tick. It accepts spawn requests over a valid/ready handshake, deletes slots by address, moves every live entity with screen-edge wrap-around, and retires entities whose lifetime expires. It sits between the input/collision logic and draw_controller, which consumes the packed `entities` bus directly.

## Interface
- N_SLOTS, 3: number of entity slots (1..16).
- SCREEN_W, 320: horizontal wrap modulus in pixels.
- SCREEN_H, 240: vertical wrap modulus in pixels.
- ADDR_W, $clog2(N_SLOTS) (minimum 1): slot address width.
- move_clk  in  1  clock; reset reset_n, synchronous, active-low, sampled on move_clk.
- reset_n  in  1  synchronous active-low reset.
- tick  in  1  one-cycle movement strobe.
- spawn_valid  in  1  spawn request.
- spawn_ready  out  1  combinational; high when at least one slot is free.
- spawn_kind  in  3  entity kind.
- spawn_life  in  4  lifetime in ticks; 0 means immortal.
- spawn_x / spawn_y  in  10 / 10  start position; must be below SCREEN_W / SCREEN_H.
- spawn_vel  in  6  {sign_y, mag_y[1:0], sign_x, mag_x[1:0]}; sign 1 means decrement.
- spawn_addr  out  ADDR_W  registered; slot used by the most recent accepted spawn.
- del_valid / del_addr  in  1 / ADDR_W  delete request for one slot.
- entities  out  N_SLOTS×34  packed slot contents, registered.
- count  out  ADDR_W+1  registered number of valid slots.
- empty / full  out  1 / 1  registered; count==0 / count==N_SLOTS.

## Operation
- Entity word: [33] valid, [32:30] kind, [29:26] life, [25:16] y, [15:6] x, [5:0] vel.
- Spawn: accepted when spawn_valid && spawn_ready. The entity is written to the lowest-index free slot with valid=1; spawn_addr takes that index. A request while full is dropped with no side effect.
- Delete: when del_valid is set, slot del_addr is cleared to all zeros. A delete of an already-invalid slot is a no-op. del_addr ≥ N_SLOTS is ignored.
- Tick: every valid slot is updated in parallel:
  - x' = x ± mag_x, modulo SCREEN_W.
  - y' = y ± mag_y, modulo SCREEN_H.
  - Wrap arithmetic is 11-bit. Increment: if x+mag ≥ W then x+mag−W. Decrement: if mag > x then x+W−mag.
  - life: 0 stays 0. life 1 clears the whole slot (expiry). Otherwise life decrements.
- Priority within one cycle, per slot: delete > tick update. The spawn target slot is chosen from pre-cycle state.
  - A slot freed by delete or expiry in cycle k is spawnable from cycle k+1.
  - A freshly spawned entity is not moved or aged in its spawn cycle, even if tick is high.
- Invalid slots are never moved and always read as all zeros.
- count, full and empty reflect post-update state one cycle after the event.

## Timing
- All state updates on posedge move_clk; write-to-visible latency is 1 cycle on entities, count, full, empty and spawn_addr.
- spawn_ready is combinational from registered slot valids and does not depend on spawn_valid.
- Reset (reset_n=0 at an edge): all slots 0, spawn_addr 0, count 0, empty 1, full 0.
  - spawn_ready is 1 after reset, since all slots are free.
  - Reset overrides spawn, delete and tick in the same cycle, including mid-operation.
- Multiple events (spawn + delete + tick) in one cycle are all applied in that cycle per the priority rules above.

## Structure
- Package entity_pkg holds:
  - ENTITY_SIZE=34 and field bit offsets;
  - typedef struct packed entity_t (valid, kind, life, y, x, vel);
  - typedef vel_t;
  - default SCREEN_W/SCREEN_H localparams.
- Sub-module entity_step: combinational single-slot next state (motion, wrap, life, expiry), instantiated N_SLOTS times via generate.
- Free-slot priority encoder and popcount stay inline in entity_pool.

## Test plan
- Reset, then spawn 3 entities with N_SLOTS=3 -> spawn_addr 0,1,2; full=1 and spawn_ready=0 after the third; a 4th request leaves all slots unchanged.
- Slot at x=318, vel sign_x=0, mag_x=3, one tick -> x=1. Slot at y=1, sign_y=1, mag_y=2 -> y=239.
- Spawn life=2, two ticks -> valid after tick 1 (life=1), slot all-zero after tick 2; count drops by 1 one cycle later. A life=0 entity survives 20 ticks.
- Full table; delete slot 1 and spawn in the same cycle -> spawn dropped. Spawn next cycle -> lands in slot 1.
- Spawn and tick in the same cycle at x=10, mag_x=1 -> entity at x=10. Next tick -> x=11.
- Assert reset_n=0 mid-stream with tick, del_valid and spawn_valid high -> all outputs at reset values next cycle.
